mips_ctl_alu_dmem: RTL and testbench

- Combines three pieces of the 5-stage MIPS CPU datapath in one block:
  - main control decoder (opcode/funct to control signals),
  - 32-bit ALU with zero flag,
  - word-organised data memory.
- Decode and ALU are combinational; memory write is synchronous; memory read is combinational.
- Used as the decode/execute/memory core of the pipelined CPU. Pipeline registers stay outside this block.

---
 rtl/mips_ctl_alu_dmem.sv | 135 +++++++++++++
 tb/tb_mips_ctl_alu_dmem.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctl_alu_dmem.sv
// Decode/execute/memory core of the 5-stage MIPS datapath: main control decoder,
// 32-bit ALU with zero flag, and a word-organised data memory with async clear.
module mips_ctl_alu_dmem #(
   parameter int unsigned NWORDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [31:0] alu_a,
   input  logic [31:0] rt_data,
   input  logic [31:0] seimm,
   output logic        regdst,
   output logic        branch_eq,
   output logic        branch_ne,
   output logic        memread,
   output logic        memwrite,
   output logic        memtoreg,
   output logic        regwrite,
   output logic        alusrc,
   output logic        jump,
   output logic [3:0]  aluctl,
   output logic [31:0] alu_out,
   output logic        zero,
   output logic [31:0] rdata,
   output logic [31:0] wb_data
);

   localparam int unsigned AW = $clog2(NWORDS);

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [3:0] AluAnd = 4'd0;
   localparam logic [3:0] AluOr  = 4'd1;
   localparam logic [3:0] AluAdd = 4'd2;
   localparam logic [3:0] AluSub = 4'd6;
   localparam logic [3:0] AluSlt = 4'd7;
   localparam logic [3:0] AluNor = 4'd12;

   logic [31:0]   alu_b;
   logic [AW-1:0] word_idx;
   logic [31:0]   mem_q [NWORDS];

   always_comb begin
      regdst    = 1'b0;
      branch_eq = 1'b0;
      branch_ne = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      alusrc    = 1'b0;
      jump      = 1'b0;
      aluctl    = AluAdd;
      case (opcode)
         OpRtype: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            case (funct)
               6'b100000: aluctl = AluAdd;
               6'b100010: aluctl = AluSub;
               6'b100100: aluctl = AluAnd;
               6'b100101: aluctl = AluOr;
               6'b101010: aluctl = AluSlt;
               6'b100111: aluctl = AluNor;
               default:   aluctl = AluAdd;
            endcase
         end
         OpLw: begin
            memread  = 1'b1;
            memtoreg = 1'b1;
            regwrite = 1'b1;
            alusrc   = 1'b1;
         end
         OpSw: begin
            memwrite = 1'b1;
            alusrc   = 1'b1;
         end
         OpAddi: begin
            regwrite = 1'b1;
            alusrc   = 1'b1;
         end
         OpBeq: begin
            branch_eq = 1'b1;
            aluctl    = AluSub;
         end
         OpBne: begin
            branch_ne = 1'b1;
            aluctl    = AluSub;
         end
         OpJ:     jump = 1'b1;
         default: ;
      endcase
   end

   assign alu_b = alusrc ? seimm : rt_data;

   always_comb begin
      alu_out = '0;
      case (aluctl)
         AluAnd:  alu_out = alu_a & alu_b;
         AluOr:   alu_out = alu_a | alu_b;
         AluAdd:  alu_out = alu_a + alu_b;
         AluSub:  alu_out = alu_a - alu_b;
         AluSlt:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
         AluNor:  alu_out = ~(alu_a | alu_b);
         default: alu_out = '0;
      endcase
   end

   assign zero = (alu_out == 32'd0);

   // Byte offset and bits above the array size are dropped, so addresses wrap.
   assign word_idx = alu_out[AW+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NWORDS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (memwrite) begin
         mem_q[word_idx] <= rt_data;
      end
   end

   assign rdata   = memread ? mem_q[word_idx] : 32'd0;
   assign wb_data = memtoreg ? rdata : alu_out;

endmodule

// File: tb/tb_mips_ctl_alu_dmem.sv
// Randomized self-checking bench for mips_ctl_alu_dmem against a table-driven
// behavioural model of decode, ALU and a plain array memory.
module tb_mips_ctl_alu_dmem;

   localparam int unsigned NWORDS = 32;

   typedef struct packed {
      logic       regdst;
      logic       branch_eq;
      logic       branch_ne;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrc;
      logic       jump;
      logic [3:0] aluctl;
   } ctl_t;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] alu_a;
   logic [31:0] rt_data;
   logic [31:0] seimm;
   logic        regdst, branch_eq, branch_ne, memread, memwrite;
   logic        memtoreg, regwrite, alusrc, jump;
   logic [3:0]  aluctl;
   logic [31:0] alu_out;
   logic        zero;
   logic [31:0] rdata;
   logic [31:0] wb_data;

   int unsigned n_checks;
   int unsigned n_errors;
   logic [31:0] model_mem [NWORDS];

   mips_ctl_alu_dmem #(.NWORDS(NWORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .funct     (funct),
      .alu_a     (alu_a),
      .rt_data   (rt_data),
      .seimm     (seimm),
      .regdst    (regdst),
      .branch_eq (branch_eq),
      .branch_ne (branch_ne),
      .memread   (memread),
      .memwrite  (memwrite),
      .memtoreg  (memtoreg),
      .regwrite  (regwrite),
      .alusrc    (alusrc),
      .jump      (jump),
      .aluctl    (aluctl),
      .alu_out   (alu_out),
      .zero      (zero),
      .rdata     (rdata),
      .wb_data   (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic ctl_t ref_ctl(input logic [5:0] op, input logic [5:0] fn);
      ctl_t c;
      c = '0;
      c.aluctl = 4'd2;
      if (op == 6'd0) begin
         c.regdst = 1'b1;
         c.regwrite = 1'b1;
         if (fn == 6'h22) c.aluctl = 4'd6;
         else if (fn == 6'h24) c.aluctl = 4'd0;
         else if (fn == 6'h25) c.aluctl = 4'd1;
         else if (fn == 6'h2a) c.aluctl = 4'd7;
         else if (fn == 6'h27) c.aluctl = 4'd12;
      end else if (op == 6'h23) begin
         c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1;
      end else if (op == 6'h2b) begin
         c.memwrite = 1'b1; c.alusrc = 1'b1;
      end else if (op == 6'h08) begin
         c.regwrite = 1'b1; c.alusrc = 1'b1;
      end else if (op == 6'h04) begin
         c.branch_eq = 1'b1; c.aluctl = 4'd6;
      end else if (op == 6'h05) begin
         c.branch_ne = 1'b1; c.aluctl = 4'd6;
      end else if (op == 6'h02) begin
         c.jump = 1'b1;
      end
      return c;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      case (c)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd12:   return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   function automatic ctl_t exp_ctl();
      return ref_ctl(opcode, funct);
   endfunction

   function automatic logic [31:0] exp_alu();
      ctl_t c;
      c = exp_ctl();
      return ref_alu(c.aluctl, alu_a, c.alusrc ? seimm : rt_data);
   endfunction

   function automatic int unsigned exp_idx();
      return (exp_alu() / 4) % NWORDS;
   endfunction

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] rt, input logic [31:0] imm);
      opcode = op; funct = fn; alu_a = a; rt_data = rt; seimm = imm;
      #1;
   endtask

   task automatic check_all(input string tag);
      ctl_t c;
      logic [31:0] r, rd;
      c  = exp_ctl();
      r  = exp_alu();
      rd = c.memread ? model_mem[exp_idx()] : 32'd0;
      check({tag, ".ctl"}, {19'd0, regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                            regwrite, alusrc, jump, aluctl}, {19'd0, c});
      check({tag, ".alu"}, alu_out, r);
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, r == 32'd0});
      check({tag, ".rdata"}, rdata, rd);
      check({tag, ".wb"}, wb_data, c.memtoreg ? rd : r);
   endtask

   // One rising edge; the model applies the write the inputs request.
   task automatic tick();
      ctl_t c;
      int unsigned idx;
      c = exp_ctl();
      idx = exp_idx();
      @(posedge clk);
      if (rst_n && c.memwrite) model_mem[idx] = rt_data;
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < int'(NWORDS); i++) model_mem[i] = 32'd0;
   endtask

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [7];
      n_checks = 0;
      n_errors = 0;
      ops = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3f};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h00};

      rst_n = 1'b0;
      model_clear();
      drive(6'h23, 6'h00, 32'd0, 32'd0, 32'd8);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rst.aluctl", {28'd0, aluctl}, 32'd2);
      check("rst.ctl", {26'd0, memread, memtoreg, alusrc, regwrite, memwrite, regdst},
            32'b111100);
      check("rst.alu", alu_out, 32'd8);
      check("rst.rdata", rdata, 32'd0);
      check("rst.wb", wb_data, 32'd0);

      drive(6'h2b, 6'h00, 32'd4, 32'hDEADBEEF, 32'd4);
      check_all("sw");
      tick();
      drive(6'h23, 6'h00, 32'd0, 32'd0, 32'd8);
      check("lw.rdata", rdata, 32'hDEADBEEF);
      check("lw.wb", wb_data, 32'hDEADBEEF);
      drive(6'h23, 6'h00, 32'h80, 32'd0, 32'd8);
      check("alias.rdata", rdata, 32'hDEADBEEF);

      drive(6'h00, 6'h24, 32'hF, 32'hF0, 32'd0);
      check("and", alu_out, 32'h0);
      check("and.zero", {31'd0, zero}, 32'd1);
      drive(6'h00, 6'h25, 32'hF, 32'hF0, 32'd0);
      check("or", alu_out, 32'hFF);
      drive(6'h00, 6'h27, 32'hF, 32'hF0, 32'd0);
      check("nor", alu_out, 32'hFFFFFF00);
      drive(6'h00, 6'h20, 32'hF, 32'hF0, 32'd0);
      check("add", alu_out, 32'hFF);
      check("add.rd_rw", {30'd0, regdst, regwrite}, 32'd3);
      drive(6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'd0);
      check("slt", alu_out, 32'd1);
      drive(6'h00, 6'h2a, 32'd1, 32'hFFFFFFFF, 32'd0);
      check("slt.swap", alu_out, 32'd0);
      check("slt.zero", {31'd0, zero}, 32'd1);

      drive(6'h04, 6'h00, 32'd5, 32'd5, 32'd0);
      check("beq", {27'd0, branch_eq, aluctl}, {27'd0, 1'b1, 4'd6});
      check("beq.zero", {31'd0, zero}, 32'd1);
      drive(6'h05, 6'h00, 32'd5, 32'd6, 32'd0);
      check("bne", {30'd0, branch_ne, zero}, 32'b10);
      drive(6'h02, 6'h00, 32'd0, 32'd0, 32'd0);
      check("j", {29'd0, jump, regwrite, memwrite}, 32'b100);

      drive(6'h2b, 6'h00, 32'd0, 32'h1234, 32'd12);
      tick();
      drive(6'h23, 6'h00, 32'd0, 32'd0, 32'd12);
      check("w3.pre", rdata, 32'h1234);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      check("w3.rst", rdata, 32'd0);
      drive(6'h2b, 6'h00, 32'd0, 32'h5555, 32'd12);
      tick();
      rst_n = 1'b1;
      drive(6'h23, 6'h00, 32'd0, 32'd0, 32'd12);
      check("w3.blocked", rdata, 32'd0);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, imm;
         a   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom;
         imm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom;
         drive(($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)],
               ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)],
               a, ($urandom_range(0, 3) == 0) ? a : $urandom, imm);
         check_all("rnd");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
